// File: rtl/conv_encoder_tx_if.sv
// Symbol-stream interface for conv_encoder_tx: frame request, channel mask,
// per-symbol valid/ready handshake and frame completion reporting.
interface conv_encoder_tx_if #(
  parameter int SEQ_LEN = 5
);
  logic                   start;
  logic [SEQ_LEN-1:0]     msg;
  logic [2*SEQ_LEN-1:0]   err_mask;
  logic                   sym_ready;
  logic [1:0]             sym_out;
  logic                   sym_valid;
  logic [2*SEQ_LEN-1:0]   clean_codeword;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output start, msg, err_mask, sym_ready,
    input  sym_out, sym_valid, clean_codeword, busy, frame_done
  );

  modport slave (
    input  start, msg, err_mask, sym_ready,
    output sym_out, sym_valid, clean_codeword, busy, frame_done
  );
endinterface

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder (G1=111, G2=101) streaming one masked
// symbol per transfer; reports the unmasked codeword when the frame completes.
module conv_encoder_tx #(
  parameter int SEQ_LEN = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_encoder_tx_if.slave bus
);
  localparam int W = 2 * SEQ_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           s;
  logic [3:0]           t;
  logic [3:0]           slot;
  logic [SEQ_LEN-1:0]   msg_sh;
  logic [W-1:0]         mask_sh;
  logic [W-1:0]         shadow, shadow_nxt;
  logic [W-1:0]         clean_q;
  logic                 b;
  logic [1:0]           enc;
  logic                 xfer;
  logic                 last;

  // msg and mask are latched as shift registers so the current bit/slice
  // always sits at the MSB end instead of being indexed by t.
  always_comb begin
    b          = msg_sh[SEQ_LEN-1];
    enc        = {b ^ s[1] ^ s[0], b ^ s[0]};
    xfer       = (state == SEND) && bus.sym_ready;
    last       = (t == 4'(SEQ_LEN - 1));
    slot       = 4'(SEQ_LEN - 1) - t;
    shadow_nxt = shadow;
    shadow_nxt[{slot, 1'b0} +: 2] = enc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEND;
      SEND:    if (xfer && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // clean_codeword is loaded on the final transfer so it is already valid
  // during the FIN cycle alongside frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      t       <= '0;
      msg_sh  <= '0;
      mask_sh <= '0;
      shadow  <= '0;
      clean_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            msg_sh  <= bus.msg;
            mask_sh <= bus.err_mask;
            s       <= '0;
            t       <= '0;
          end
        end
        SEND: begin
          if (xfer) begin
            s       <= {b, s[1]};
            t       <= t + 4'd1;
            msg_sh  <= msg_sh << 1;
            mask_sh <= mask_sh << 2;
            shadow  <= shadow_nxt;
            if (last) clean_q <= shadow_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.sym_valid  = (state == SEND);
    bus.sym_out    = (state == SEND) ? (enc ^ mask_sh[W-1 -: 2]) : 2'b00;
    bus.busy       = (state != IDLE);
    bus.frame_done = (state == FIN);
  end

  assign bus.clean_codeword = clean_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx with hand-computed symbol sequences.
module tb_conv_encoder_tx;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  conv_encoder_tx_if #(.SEQ_LEN(5)) bus ();

  conv_encoder_tx #(.SEQ_LEN(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b0; bus.msg = '0; bus.err_mask = '0; bus.sym_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.sym_valid); end
    total++; if (bus.sym_out !== 2'b00) begin bad++; $display("FAIL rst_sym: got %b want 00", bus.sym_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.frame_done); end
    total++; if (bus.clean_codeword !== 10'b0) begin bad++; $display("FAIL rst_clean: got %b want 0", bus.clean_codeword); end
    rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_clean_frame(input logic [4:0] m, input logic [9:0] mask,
                                  input logic [9:0] exp_sym, input logic [9:0] exp_clean);
    logic [1:0] e;
    bus.msg = m; bus.err_mask = mask; bus.sym_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = exp_sym[2*(4-i) +: 2];
      total++; if (bus.sym_valid !== 1'b1) begin bad++; $display("FAIL frame_valid%0d: got %b want 1", i, bus.sym_valid); end
      total++; if (bus.sym_out !== e) begin bad++; $display("FAIL frame_sym%0d: got %b want %b", i, bus.sym_out, e); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL frame_busy%0d: got %b want 1", i, bus.busy); end
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL frame_early_done%0d: got %b want 0", i, bus.frame_done); end
      tick();
    end
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL frame_done: got %b want 1", bus.frame_done); end
    total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL fin_valid: got %b want 0", bus.sym_valid); end
    total++; if (bus.clean_codeword !== exp_clean) begin bad++; $display("FAIL frame_clean: got %b want %b", bus.clean_codeword, exp_clean); end
    tick();
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", bus.frame_done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_sym;
    logic [1:0] e;
    exp_sym = 10'b11_01_10_10_10;
    bus.msg = 5'b11111; bus.err_mask = '0; bus.sym_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if (bus.sym_out !== 2'b11) begin bad++; $display("FAIL bp_sym0: got %b want 11", bus.sym_out); end
    tick();
    bus.sym_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.sym_out !== 2'b01 || bus.sym_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d: got %b/%b want 01/1", i, bus.sym_out, bus.sym_valid); end
      tick();
    end
    bus.sym_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      e = exp_sym[2*(4-i) +: 2];
      total++; if (bus.sym_out !== e) begin bad++; $display("FAIL bp_sym%0d: got %b want %b", i, bus.sym_out, e); end
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL bp_early_done%0d: got %b want 0", i, bus.frame_done); end
      tick();
    end
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", bus.frame_done); end
    total++; if (bus.clean_codeword !== exp_sym) begin bad++; $display("FAIL bp_clean: got %b want %b", bus.clean_codeword, exp_sym); end
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [9:0] exp_sym;
    logic [1:0] e;
    exp_sym = 10'b1110000101;
    bus.msg = 5'b10110; bus.err_mask = '0; bus.sym_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin bus.start = 1'b1; bus.msg = 5'b11111; bus.err_mask = '1; end
      else bus.start = 1'b0;
      e = exp_sym[2*(4-i) +: 2];
      total++; if (bus.sym_out !== e) begin bad++; $display("FAIL busy_sym%0d: got %b want %b", i, bus.sym_out, e); end
      tick();
    end
    bus.start = 1'b0;
    total++; if (bus.clean_codeword !== exp_sym) begin bad++; $display("FAIL busy_clean: got %b want %b", bus.clean_codeword, exp_sym); end
    tick();
    tick();
    total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL busy_ignored: got %b want 0", bus.sym_valid); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_sym;
    logic [1:0] e;
    exp_sym = 10'b11_10_11_00_00;
    bus.msg = 5'b00000; bus.err_mask = '0; bus.sym_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.msg = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.sym_out !== 2'b00) begin bad++; $display("FAIL b2b_a_sym%0d: got %b want 00", i, bus.sym_out); end
      tick();
    end
    total++; if (bus.frame_done !== 1'b1 || bus.clean_codeword !== 10'b0) begin bad++; $display("FAIL b2b_a_done: got %b/%b want 1/0", bus.frame_done, bus.clean_codeword); end
    tick();
    total++; if (bus.sym_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b/%b want 0/0", bus.sym_valid, bus.busy); end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.start = 1'b0;
      e = exp_sym[2*(4-i) +: 2];
      total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== e) begin bad++; $display("FAIL b2b_b_sym%0d: got %b/%b want 1/%b", i, bus.sym_valid, bus.sym_out, e); end
      tick();
    end
    total++; if (bus.frame_done !== 1'b1 || bus.clean_codeword !== exp_sym) begin bad++; $display("FAIL b2b_b_done: got %b/%b want 1/%b", bus.frame_done, bus.clean_codeword, exp_sym); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    bus.msg = 5'b10110; bus.err_mask = '0; bus.sym_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    total++; if (bus.sym_out !== 2'b00 || bus.sym_valid !== 1'b1) begin bad++; $display("FAIL mid_sym2: got %b/%b want 00/1", bus.sym_out, bus.sym_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.sym_valid); end
    total++; if (bus.clean_codeword !== 10'b0) begin bad++; $display("FAIL mid_clean: got %b want 0", bus.clean_codeword); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.frame_done !== 1'b0 || bus.sym_valid !== 1'b0) begin bad++; $display("FAIL mid_quiet%0d: got %b/%b want 0/0", i, bus.frame_done, bus.sym_valid); end
      tick();
    end
    test_clean_frame(5'b10110, 10'b0, 10'b1110000101, 10'b1110000101);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_frame(5'b10110, 10'b0, 10'b1110000101, 10'b1110000101);
    test_clean_frame(5'b10110, 10'b0000100000, 10'b1110100101, 10'b1110000101);
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/conv_encoder_tx.md
# conv_encoder_tx

Rate-1/2, K=3 convolutional encoder (G1=111, G2=101) that sits directly upstream of the Viterbi decoder stage. It accepts one SEQ_LEN-bit message frame, encodes it starting from state 00, and streams one 2-bit symbol per transfer into the decoder's `in_sym`/`in_valid` port. A per-frame error mask is XORed onto the symbols to emulate a noisy channel. The clean (unmasked) codeword is reported separately so a bench can compare it against the decoder's `corrected_codeword`.

## Interface
- `SEQ_LEN`, default 5, number of message bits and symbols per frame (2..15).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `msg`  in  SEQ_LEN  message; `msg[SEQ_LEN-1]` is encoded first (time 0).
- `err_mask`  in  2*SEQ_LEN  channel error pattern; bits `[2*(SEQ_LEN-1-t)+:2]` are XORed onto symbol t.
- `sym_ready`  in  1  downstream accept; tie to 1 when driving the decoder directly.
- `sym_out`  out  2  transmitted symbol, {G1 bit, G2 bit}.
- `sym_valid`  out  1  `sym_out` holds a valid symbol.
- `clean_codeword`  out  2*SEQ_LEN  unmasked codeword of the last completed frame; symbol 0 in the MSBs.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `frame_done` pulses.
- `frame_done`  out  1  one-cycle pulse after the last symbol transfers.

## Operation
- States: IDLE, SEND, FIN.
- **IDLE**
  - When `start`=1: latch `msg` and `err_mask`, clear the encoder state and symbol index t to 0, and go to SEND.
  - A `start` seen outside IDLE is ignored. Inputs are not re-sampled during a frame.
- **SEND**
  - `sym_valid`=1.
  - `sym_out` = enc(s, b) XOR mask slice t, where b = latched `msg[SEQ_LEN-1-t]`.
  - enc(s, b) forms the 3-bit shift value {b, s[1], s[0]}:
    - G1 bit = b^s[1]^s[0]
    - G2 bit = b^s[0]
  - On a transfer (`sym_valid`&`sym_ready` at a clock edge):
    - s <= {b, s[1]}.
    - The clean symbol enc(s, b) is written into a shadow register at bits `[2*(SEQ_LEN-1-t)+:2]`.
    - t increments.
  - The transfer with t=SEQ_LEN-1 moves the FSM to FIN.
  - No tail/flush bits are appended; the frame ends in whatever state the message leaves.
- **Backpressure**: while `sym_valid`=1 and `sym_ready`=0, `sym_out`, s and t hold exactly.
- **FIN**: `clean_codeword` <= shadow register, `frame_done`=1 for this cycle, `sym_valid`=0, then go to IDLE.
- **Masking**: the mask affects only `sym_out`, never `clean_codeword` or the encoder state.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - FSM goes to IDLE; s=00; t=0.
  - `sym_out`=00, `sym_valid`=0, `clean_codeword`=0, `busy`=0, `frame_done`=0.
  - The latched msg/mask and the shadow register clear to 0.
- **Reset mid-frame**: the frame is abandoned; `sym_valid` drops immediately and `clean_codeword` is not updated. No partial `frame_done` is produced.
- **Latency**:
  - `start` sampled at edge E0; `sym_valid` first high after E0 (cycle 1).
  - With `sym_ready`=1 throughout, symbols 0..SEQ_LEN-1 transfer at edges E1..E_SEQ_LEN.
  - FIN occupies the next cycle, so `frame_done` and the new `clean_codeword` are visible after edge E_SEQ_LEN.
  - The block is back in IDLE after E_SEQ_LEN+1. Minimum start-to-start spacing is SEQ_LEN+2 cycles.
- **Output registers**: all outputs are registered; `sym_out` is combinational from registered s/t/msg/mask only (no input-to-output path).
- **`start` held high**: a new frame is accepted the first IDLE cycle after FIN.
- **Decoder pairing**: the decoder samples only in its LOAD state, so after reset the bench asserts `start` no earlier than 3 cycles after `rst_n` rises.

## Test plan
- **Clean frame**: msg=10110, err_mask=0, `sym_ready`=1 → `sym_out` sequence 11,10,00,01,01 on 5 consecutive cycles; `clean_codeword`=1110000101; single `frame_done`; decoder outputs `decoded_bits`=10110.
- **Single error**: same msg, err_mask=0000100000 → symbol 2 sent as 10 and the others unchanged; `clean_codeword` still 1110000101; decoder still recovers 10110.
- **Backpressure**: msg=11111, `sym_ready` low for 3 cycles while symbol 1 is pending → `sym_out`=01 held stable, full sequence 11,01,10,10,10 emitted, `frame_done` delayed by exactly 3 cycles.
- **Start while busy / back-to-back**: `start` pulsed mid-frame → ignored. With `start` held high across two frames (msg 00000 then 10000), the second frame's first `sym_valid` follows FIN by one cycle and emits 11,10,11,00,00.
- **Reset mid-frame**: assert `rst_n`=0 after symbol 2 → `sym_valid`=0 immediately, no `frame_done`, `clean_codeword`=0. A following frame of msg=10110 encodes from state 00 exactly as in the clean-frame scenario.
